// File: rtl/alarm_ring_ctrl_pkg.sv
// alarm_ring_ctrl_pkg: state encodings and beat-counter width shared by the alarm ring controller
package alarm_ring_ctrl_pkg;
  localparam int CNT_W = 10;
  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2, HOLD = 2'd3} state_t;
endpackage

// File: rtl/alarm_ring_ctrl_rise_edge.sv
// rise_edge: registered rising-edge detector, pulses in the first cycle the input is seen high
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  logic q;
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= 1'b0;
    else q <= d;
  assign pulse = d & ~q;
endmodule

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: gates the ring tone onto the buzzer with stop, snooze, timeout and retrigger hold
module alarm_ring_ctrl
  import alarm_ring_ctrl_pkg::*;
#(
  parameter int RING_BEATS   = 120,
  parameter int SNOOZE_BEATS = 600,
  parameter int MAX_SNOOZES  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ring_in,
  input  logic       alarm_en,
  input  logic       alarm_match,
  input  logic       stop,
  input  logic       snooze,
  output logic       ring_out,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt
);
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_BEATS - 1);
  localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_BEATS - 1);
  localparam logic [1:0]       MAX_S     = 2'(MAX_SNOOZES);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic beat, stop_p, snooze_p, halt;
  rise_edge u_beat   (.clk(clk), .reset(reset), .d(ring_in), .pulse(beat));
  rise_edge u_stop   (.clk(clk), .reset(reset), .d(stop),    .pulse(stop_p));
  rise_edge u_snooze (.clk(clk), .reset(reset), .d(snooze),  .pulse(snooze_p));
  assign halt = stop_p | ~alarm_en;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (alarm_en & alarm_match) ? RING : IDLE;
      RING:    nxt = halt ? HOLD :
                     (snooze_p && snooze_cnt < MAX_S) ? SNOOZE :
                     (beat && cnt == RING_LAST) ? HOLD : RING;
      SNOOZE:  nxt = halt ? HOLD : (beat && cnt == SNZ_LAST) ? RING : SNOOZE;
      default: nxt = alarm_match ? HOLD : IDLE;
    endcase
  end
  // Outputs are decided from the next state so they line up with the registered state.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      snooze_cnt <= '0;
      ring_out   <= 1'b0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? '0 : cnt + CNT_W'(beat);
      if (state == IDLE && nxt == RING) snooze_cnt <= '0;
      else if (state == RING && nxt == SNOOZE) snooze_cnt <= snooze_cnt + 2'd1;
      ring_out <= ring_in & (nxt == RING);
      ringing  <= nxt == RING;
      snoozing <= nxt == SNOOZE;
    end
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: scoreboard bench with a behavioural alarm model and random button/match stimulus
module tb_alarm_ring_ctrl;
  localparam int RB = 4, SB = 3, MS = 2;
  logic clk = 0, reset = 1, ring_in = 0, alarm_en = 0, alarm_match = 0, stop = 0, snooze = 0;
  logic ring_out, ringing, snoozing;
  logic [1:0] snooze_cnt;
  typedef struct {logic ro; logic rg; logic sz; logic [1:0] sc;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, ph = 0;
  bit m_ring, m_snz, m_hold, p_ri, p_st, p_sn, last_ro;
  int beats, used;

  alarm_ring_ctrl #(.RING_BEATS(RB), .SNOOZE_BEATS(SB), .MAX_SNOOZES(MS)) dut (
    .clk(clk), .reset(reset), .ring_in(ring_in), .alarm_en(alarm_en),
    .alarm_match(alarm_match), .stop(stop), .snooze(snooze),
    .ring_out(ring_out), .ringing(ringing), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ring_out", ring_out, e.ro);
      chk("ringing", ringing, e.rg);
      chk("snoozing", snoozing, e.sz);
      chk("snooze_cnt", snooze_cnt, e.sc);
    end

  task automatic model_reset();
    m_ring = 0; m_snz = 0; m_hold = 0; beats = 0; used = 0;
    p_ri = 0; p_st = 0; p_sn = 0;
  endtask

  task automatic go_hold();
    m_ring = 0; m_snz = 0; m_hold = 1; beats = 0;
  endtask

  // One clock of stimulus: square-wave ring tone, model update, expected outputs queued.
  task automatic step();
    bit beat, sp, snp;
    ring_in = (ph % 8) < 4;
    ph++;
    beat = ring_in && !p_ri;
    sp = stop && !p_st;
    snp = snooze && !p_sn;
    p_ri = ring_in; p_st = stop; p_sn = snooze;
    if (m_hold) begin
      if (!alarm_match) m_hold = 0;
    end else if (m_ring) begin
      if (sp || !alarm_en) go_hold();
      else if (snp && used < MS) begin
        m_ring = 0; m_snz = 1; beats = 0; used++;
      end else begin
        if (beat) beats++;
        if (beats == RB) go_hold();
      end
    end else if (m_snz) begin
      if (sp || !alarm_en) go_hold();
      else begin
        if (beat) beats++;
        if (beats == SB) begin m_snz = 0; m_ring = 1; beats = 0; end
      end
    end else if (alarm_en && alarm_match) begin
      m_ring = 1; beats = 0; used = 0;
    end
    last_ro = ring_in && m_ring;
    q.push_back('{last_ro, m_ring, m_snz, 2'(used)});
    @(posedge clk); #1;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic press_snooze();
    snooze = 1; run(2); snooze = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ring_out", ring_out, 0);
    chk("reset_ringing", ringing, 0);
    chk("reset_snoozing", snoozing, 0);
    chk("reset_snooze_cnt", snooze_cnt, 0);
    #1 reset = 0;
    alarm_en = 1; alarm_match = 1; run(40);
    alarm_match = 0; run(4);
    alarm_match = 1; run(10); press_snooze(); run(30);
    stop = 1; run(2); stop = 0; alarm_match = 0; run(3);
    alarm_match = 1; run(6); press_snooze(); run(30);
    press_snooze(); run(30);
    press_snooze(); run(40);
    alarm_match = 0; run(3);
    alarm_match = 1; run(6);
    stop = 1; snooze = 1; run(2); stop = 0; snooze = 0; run(3);
    alarm_match = 0; run(3);
    stop = 1; alarm_match = 1; run(45);
    alarm_match = 0; run(2); alarm_match = 1; run(12);
    stop = 0; run(2); stop = 1; run(2);
    alarm_match = 0; stop = 0; run(3);
    alarm_match = 1; last_ro = 0;
    for (int i = 0; i < 40 && !last_ro; i++) step();
    @(negedge clk);
    chk("pre_reset_ring_out", ring_out, 1);
    #1 reset = 1;
    #1;
    chk("async_ring_out", ring_out, 0);
    chk("async_ringing", ringing, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 0;
    run(12);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) stop = ~stop;
      if ($urandom_range(0, 11) == 0) snooze = ~snooze;
      if ($urandom_range(0, 59) == 0) alarm_match = ~alarm_match;
      alarm_en = $urandom_range(0, 149) != 0;
      step();
    end
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
